// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - shared types and sizing for the data-memory bridge
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDONE = 2'd3
    } state_t;

    localparam int WBUF_DEPTH = 2;

endpackage

// File: rtl/dmem_bridge_if.sv
// rtl/dmem_bridge_if.sv - controller-side and memory-side bundles of the bridge
interface dmem_cpu_if #(
    parameter int N = 16
);
    logic         memread;
    logic         memwrite;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         stall;

    modport master (output memread, memwrite, addr, wdata, input rdata, stall);
    modport slave  (input memread, memwrite, addr, wdata, output rdata, stall);
endinterface

interface dmem_mem_if #(
    parameter int N = 16
);
    logic         m_req;
    logic         m_we;
    logic [N-1:0] m_addr;
    logic [N-1:0] m_wdata;
    logic         m_ack;
    logic [N-1:0] m_rdata;

    modport master (output m_req, m_we, m_addr, m_wdata, input m_ack, m_rdata);
    modport slave  (input m_req, m_we, m_addr, m_wdata, output m_ack, m_rdata);
endinterface

// File: rtl/dmem_bridge_wbuf_fifo.sv
// rtl/dmem_bridge_wbuf_fifo.sv - in-order posted-store buffer holding {addr,data}
module wbuf_fifo #(
    parameter int n     = 16,
    parameter int depth = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [n-1:0] push_addr,
    input  logic [n-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [n-1:0] head_addr,
    output logic [n-1:0] head_data
);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(depth);
    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);

    logic [n-1:0]  r_addr [depth];
    logic [n-1:0]  r_data [depth];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign head_addr = r_addr[r_rd_ptr];
    assign head_data = r_data[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only observed while the count says it is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= push_addr;
            r_data[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - stalling data-memory bridge with posted stores and ordered loads
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int n = 16
) (
    input  logic       clk,
    input  logic       reset,
    dmem_cpu_if.slave  cpu,
    dmem_mem_if.master mem
);
    state_t       r_state;
    state_t       w_next;
    logic [n-1:0] r_m_addr;
    logic [n-1:0] r_m_wdata;
    logic [n-1:0] r_rdata;
    logic         w_full;
    logic         w_empty;
    logic [n-1:0] w_head_addr;
    logic [n-1:0] w_head_data;
    logic         w_push;
    logic         w_pop;
    logic         w_load_wr;
    logic         w_load_rd;
    logic         w_capture;
    logic         w_req;
    logic         w_we;
    logic         w_stall;

    // A load always yields to the store path; memwrite alongside memread is dropped.
    assign w_push  = cpu.memwrite && !cpu.memread && !w_full;
    assign w_stall = reset && ((cpu.memread && (r_state != RDONE)) ||
                               (cpu.memwrite && !cpu.memread && w_full));

    wbuf_fifo #(
        .n     (n),
        .depth (WBUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_addr (cpu.addr),
        .push_data (cpu.wdata),
        .full      (w_full),
        .empty     (w_empty),
        .head_addr (w_head_addr),
        .head_data (w_head_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_load_wr = 1'b0;
        w_load_rd = 1'b0;
        w_capture = 1'b0;
        w_req     = 1'b0;
        w_we      = 1'b0;
        case (r_state)
            IDLE: begin
                // Draining stores first gives store-to-load ordering without forwarding.
                if (!w_empty) begin
                    w_next    = WR;
                    w_load_wr = 1'b1;
                end else if (cpu.memread) begin
                    w_next    = RD;
                    w_load_rd = 1'b1;
                end
            end
            WR: begin
                w_req = 1'b1;
                w_we  = 1'b1;
                if (mem.m_ack) begin
                    w_pop  = 1'b1;
                    w_next = IDLE;
                end
            end
            RD: begin
                w_req = 1'b1;
                if (mem.m_ack) begin
                    w_capture = 1'b1;
                    w_next    = RDONE;
                end
            end
            RDONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Address/data are latched on entry so they stay frozen for the whole request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_load_wr) begin
                r_m_addr  <= w_head_addr;
                r_m_wdata <= w_head_data;
            end else if (w_load_rd) begin
                r_m_addr  <= cpu.addr;
            end
            if (w_capture) begin
                r_rdata <= mem.m_rdata;
            end
        end
    end

    assign mem.m_req   = w_req;
    assign mem.m_we    = w_we;
    assign mem.m_addr  = r_m_addr;
    assign mem.m_wdata = r_m_wdata;
    assign cpu.rdata   = r_rdata;
    assign cpu.stall   = w_stall;

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 The parameter SHALL be: n, default 16, data and address width in bits.
REQ-002 Port clk SHALL be: clk  input  1  single clock, all state on rising edge.
REQ-003 Port reset SHALL be: reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 Port memread SHALL be: memread  input  1  load request from controller, held until stall low.
REQ-005 Port memwrite SHALL be: memwrite  input  1  store request from controller.
REQ-006 Port addr SHALL be: addr  input  n  byte address, driven from datapath aluout.
REQ-007 Port wdata SHALL be: wdata  input  n  store data, driven from datapath writedata.
REQ-008 Port rdata SHALL be: rdata  output  n  registered load data, driven to datapath readdata.
REQ-009 Port stall SHALL be: stall  output  1  freezes PC and pipeline state when 1.
REQ-010 Memory-side ports SHALL be: m_req out 1, m_we out 1, m_addr out n, m_wdata out n, m_ack in 1, m_rdata in n.

Function
REQ-011 The FSM SHALL have states IDLE, WR (drain one buffered store), RD (issue load), RDONE (load data valid).
REQ-012 Stores SHALL be posted into a 2-entry in-order write buffer; with buffer not full and memread=0, memwrite SHALL enqueue {addr,wdata} at the edge with stall=0.
REQ-013 With buffer full, memwrite SHALL raise stall until count<2; a same-cycle m_ack on the head SHALL NOT clear stall in that cycle.
REQ-014 In IDLE with buffer non-empty and memread=0, the FSM SHALL enter WR, driving m_req=1, m_we=1, and the head entry on m_addr/m_wdata.
REQ-015 m_req, m_we, m_addr and m_wdata SHALL remain stable until m_ack is sampled 1; m_req SHALL then be 0 for at least one cycle.
REQ-016 On m_ack in WR, the head SHALL be popped and the FSM SHALL return to IDLE.
REQ-017 memread SHALL drive stall=1 combinationally in IDLE, WR and RD; loads SHALL wait until the write buffer is empty (strict store-to-load ordering, no forwarding).
REQ-018 From IDLE with memread=1 and the buffer empty, the FSM SHALL enter RD with m_req=1, m_we=0, m_addr=addr.
REQ-019 On m_ack in RD, rdata SHALL capture m_rdata and the FSM SHALL enter RDONE.
REQ-020 In RDONE, stall SHALL be 0, and the FSM SHALL return to IDLE next cycle regardless of memread.
REQ-021 Minimum load latency SHALL be 3 cycles from first memread to the advancing edge (ack on first RD cycle).
REQ-022 With memread and memwrite both 1, the read SHALL take priority and the store SHALL be ignored.
REQ-023 rdata SHALL hold its last loaded value until the next load completes.

Reset
REQ-024 While reset=0, the bridge SHALL drive state=IDLE, write buffer empty, rdata=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, stall=0.
REQ-025 Reset mid-transaction SHALL abandon the transaction and discard buffered stores; a late m_ack in IDLE SHALL be ignored.

Structure
REQ-026 Package dmem_bridge_pkg SHALL hold the state enum and WBUF_DEPTH=2.
REQ-027 The write buffer SHALL be sub-module wbuf_fifo (parameterised n, depth) with push, pop, full, empty, head outputs.

Verification
REQ-028 Store 0x0040<-0xBEEF, ack after 2 cycles -> stall stays 0; m_req/m_we hold 0x0040/0xBEEF until ack; buffer empties.
REQ-029 Three back-to-back stores, memory ack withheld -> stall=1 on the third store until the first ack, then the third enqueues.
REQ-030 Store 0x0010<-0x1234 then immediate load 0x0010, memory returns 0x1234 -> write issued before read; rdata=0x1234; stall drops in RDONE.
REQ-031 Load with buffer empty and immediate ack -> stall high for exactly 2 cycles, low in RDONE; rdata=m_rdata.
REQ-032 reset=0 asserted while in RD with one store buffered -> all outputs reach reset values at once; a subsequent ack is ignored.
REQ-033 memread=memwrite=1 at 0x0020 -> only a read is issued; buffer count unchanged.
